// File: rtl/bk_sd_sequencer.sv
// Backup-RAM save/load sequencer between core BRAM and the hps_io SD
// sector interface, with dirty-tracked autosave and media-loss abort.
module bk_sd_sequencer #(
    parameter int unsigned SECTORS      = 128,
    parameter int unsigned LBA_BASE     = 0,
    parameter int unsigned LBA_W        = 32,
    parameter int unsigned AUTOSAVE_CYC = 50000000
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             bk_ena,
    input  logic             load_req,
    input  logic             save_req,
    input  logic             dl_done,
    input  logic             autosave_en,
    input  logic             bram_wr,
    input  logic             sd_ack,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    output logic             busy,
    output logic             loading,
    output logic             dirty,
    output logic             done,
    output logic             abort
);

    localparam int unsigned IW = (SECTORS > 1) ? $clog2(SECTORS) : 1;
    localparam int unsigned TW = (AUTOSAVE_CYC > 1) ? $clog2(AUTOSAVE_CYC) : 1;
    localparam logic [IW-1:0]    IDX_LAST = IW'(SECTORS - 1);
    localparam logic [TW-1:0]    TMR_LAST = TW'(AUTOSAVE_CYC - 1);
    localparam logic [LBA_W-1:0] BASE     = LBA_W'(LBA_BASE);
    localparam bit               AUTO_ON  = (AUTOSAVE_CYC != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [LBA_W-1:0] lba_d;
    logic             op_load_q, op_load_d;
    logic             rd_d, wr_d, loading_d, dirty_d, done_d, abort_d;
    logic             load_q, save_q, ack_q;

    logic load_rise, save_rise, ack_rise, ack_fall;
    logic timer_run, auto_hit, start, is_load;

    assign load_rise = load_req & ~load_q;
    assign save_rise = save_req & ~save_q;
    assign ack_rise  = sd_ack & ~ack_q;
    assign ack_fall  = ~sd_ack & ack_q;

    assign timer_run = AUTO_ON && (state_q == S_IDLE) && dirty
                       && autosave_en && bk_ena;
    assign auto_hit  = timer_run && (timer_q == TMR_LAST);

    // Trigger priority: download end, then load, then save, then autosave.
    assign is_load = dl_done | load_rise;
    assign start   = bk_ena & (is_load | save_rise | auto_hit);

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            op_load_q <= 1'b0;
            sd_lba    <= BASE;
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            loading   <= 1'b0;
            dirty     <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
            load_q    <= 1'b0;
            save_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            op_load_q <= op_load_d;
            sd_lba    <= lba_d;
            sd_rd     <= rd_d;
            sd_wr     <= wr_d;
            loading   <= loading_d;
            dirty     <= dirty_d;
            done      <= done_d;
            abort     <= abort_d;
            load_q    <= load_req;
            save_q    <= save_req;
            ack_q     <= sd_ack;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        op_load_d = op_load_q;
        lba_d     = sd_lba;
        rd_d      = sd_rd;
        wr_d      = sd_wr;
        loading_d = loading;
        dirty_d   = dirty | bram_wr;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        timer_d   = timer_run ? timer_q + TW'(1) : '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_REQ;
                    idx_d     = '0;
                    lba_d     = BASE;
                    op_load_d = is_load;
                    loading_d = is_load;
                    rd_d      = is_load;
                    wr_d      = ~is_load;
                    timer_d   = '0;
                    if (!is_load) begin
                        dirty_d = bram_wr;
                    end
                end
            end
            S_REQ: begin
                if (!bk_ena) begin
                    state_d   = S_IDLE;
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    loading_d = 1'b0;
                    abort_d   = 1'b1;
                end else if (ack_rise) begin
                    state_d = S_XFER;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            S_XFER: begin
                if (!bk_ena) begin
                    state_d   = S_IDLE;
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    loading_d = 1'b0;
                    abort_d   = 1'b1;
                end else if (ack_fall) begin
                    if (idx_q == IDX_LAST) begin
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
                        loading_d = 1'b0;
                        if (op_load_q) begin
                            dirty_d = bram_wr;
                        end
                    end else begin
                        state_d = S_REQ;
                        idx_d   = idx_q + IW'(1);
                        lba_d   = sd_lba + LBA_W'(1);
                        rd_d    = op_load_q;
                        wr_d    = ~op_load_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bk_sd_sequencer.sv
// Randomized bench for bk_sd_sequencer: acts as the hps_io sector
// responder and checks each transfer against a transaction-level model.
module tb_bk_sd_sequencer;

    localparam int SECTORS  = 4;
    localparam int LBA_BASE = 64;
    localparam int LBA_W    = 16;
    localparam int AUTO_CYC = 16;

    logic             clk_sys = 1'b0;
    logic             reset;
    logic             bk_ena, load_req, save_req, dl_done;
    logic             autosave_en, bram_wr, sd_ack;
    logic [LBA_W-1:0] sd_lba;
    logic             sd_rd, sd_wr, busy, loading, dirty, done, abort;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  m_dirty;
    bit  wrote;
    int  kind;
    int  cnt;

    bk_sd_sequencer #(
        .SECTORS     (SECTORS),
        .LBA_BASE    (LBA_BASE),
        .LBA_W       (LBA_W),
        .AUTOSAVE_CYC(AUTO_CYC)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bk_ena     (bk_ena),
        .load_req   (load_req),
        .save_req   (save_req),
        .dl_done    (dl_done),
        .autosave_en(autosave_en),
        .bram_wr    (bram_wr),
        .sd_ack     (sd_ack),
        .sd_lba     (sd_lba),
        .sd_rd      (sd_rd),
        .sd_wr      (sd_wr),
        .busy       (busy),
        .loading    (loading),
        .dirty      (dirty),
        .done       (done),
        .abort      (abort)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    // kind: 0 = dl_done pulse, 1 = load_req rise, 2 = save_req rise
    task automatic start(input int k);
        case (k)
            0:       dl_done = 1'b1;
            1:       load_req = 1'b1;
            default: save_req = 1'b1;
        endcase
        tick();
        dl_done = 1'b0;
    endtask

    // Plays hps_io for one transfer. stop_at >= 0 interrupts at that
    // sector (media loss, or async reset when by_rst is set).
    task automatic serve(input bit ld, input int stop_at, input bit by_rst,
                         input bit force_wr, output bit wr_seen);
        int d;
        wr_seen = 1'b0;
        for (int i = 0; i < SECTORS; i++) begin
            d = 0;
            while (!(sd_rd || sd_wr) && d < 8) begin
                tick();
                d++;
            end
            check("req_seen", 32'(sd_rd | sd_wr), 32'd1);
            if (!(sd_rd || sd_wr)) return;
            check("lba", 32'(sd_lba), 32'(LBA_BASE + i));
            check("rd", 32'(sd_rd), 32'(ld));
            check("wr", 32'(sd_wr), 32'(!ld));
            check("loading", 32'(loading), 32'(ld));
            check("busy", 32'(busy), 32'd1);
            if (i == stop_at) begin
                if (by_rst) begin
                    #2 reset = 1'b1;
                    #1;
                    check("rst_rd", 32'(sd_rd), 32'd0);
                    check("rst_wr", 32'(sd_wr), 32'd0);
                    check("rst_busy", 32'(busy), 32'd0);
                    check("rst_loading", 32'(loading), 32'd0);
                    check("rst_dirty", 32'(dirty), 32'd0);
                    check("rst_lba", 32'(sd_lba), 32'(LBA_BASE));
                    save_req = 1'b0;
                    load_req = 1'b0;
                    @(negedge clk_sys);
                    reset = 1'b0;
                end else begin
                    bk_ena = 1'b0;
                    tick();
                    check("abt_rd", 32'(sd_rd), 32'd0);
                    check("abt_loading", 32'(loading), 32'd0);
                    check("abt_pulse", 32'(abort), 32'd1);
                    check("abt_busy", 32'(busy), 32'd0);
                    check("abt_done", 32'(done), 32'd0);
                    tick();
                    check("abt_pulse_end", 32'(abort), 32'd0);
                    check("abt_no_done", 32'(done), 32'd0);
                    bk_ena = 1'b1;
                end
                return;
            end
            repeat ($urandom_range(0, 3)) tick();
            if (force_wr || $urandom_range(0, 3) == 0) begin
                bram_wr = 1'b1;
                wr_seen = 1'b1;
            end
            sd_ack = 1'b1;
            tick();
            bram_wr = 1'b0;
            check("req_drop", 32'(sd_rd | sd_wr), 32'd0);
            repeat ($urandom_range(0, 3)) tick();
            sd_ack = 1'b0;
            tick();
            check("done", 32'(done), 32'(i == SECTORS - 1));
            if (i == SECTORS - 1) begin
                check("end_busy", 32'(busy), 32'd0);
                check("end_loading", 32'(loading), 32'd0);
                check("end_rd", 32'(sd_rd | sd_wr), 32'd0);
                tick();
                check("done_pulse", 32'(done), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bk_ena      = 1'b1;
        load_req    = 1'b0;
        save_req    = 1'b0;
        dl_done     = 1'b0;
        autosave_en = 1'b0;
        bram_wr     = 1'b0;
        sd_ack      = 1'b0;
        m_dirty     = 1'b0;
        repeat (3) tick();
        check("rst_lba0", 32'(sd_lba), 32'(LBA_BASE));
        check("rst_out0", {25'd0, sd_rd, sd_wr, busy, loading,
                           dirty, done, abort}, 32'd0);
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Random mix of loads and saves, with optional core writes.
        for (int n = 0; n < 10; n++) begin
            kind = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                bram_wr = 1'b1;
                tick();
                bram_wr = 1'b0;
                m_dirty = 1'b1;
            end
            check("dirty_pre", 32'(dirty), 32'(m_dirty));
            start(kind);
            check("dirty_start", 32'(dirty), (kind == 2) ? 32'd0 : 32'(m_dirty));
            serve(kind != 2, -1, 1'b0, 1'b0, wrote);
            m_dirty = (kind == 2) ? wrote : 1'b0;
            check("dirty_end", 32'(dirty), 32'(m_dirty));
            load_req = 1'b0;
            save_req = 1'b0;
            repeat (2) tick();
        end

        // Simultaneous dl_done and save rise: load wins, save is dropped.
        dl_done  = 1'b1;
        save_req = 1'b1;
        tick();
        dl_done = 1'b0;
        serve(1'b1, -1, 1'b0, 1'b0, wrote);
        m_dirty = 1'b0;
        repeat (6) tick();
        check("no_late_save", 32'(busy | sd_wr), 32'd0);
        check("dirty_after_ld", 32'(dirty), 32'(m_dirty));
        save_req = 1'b0;
        tick();

        // Autosave fires 17 cycles after a single write pulse.
        autosave_en = 1'b1;
        bram_wr     = 1'b1;
        cnt         = 0;
        tick();
        cnt++;
        bram_wr = 1'b0;
        while (!sd_wr && cnt < 40) begin
            tick();
            cnt++;
        end
        check("auto_delay", 32'(cnt), 32'd17);
        check("auto_dirty_clr", 32'(dirty), 32'd0);
        serve(1'b0, -1, 1'b0, 1'b1, wrote);
        check("auto_dirty_kept", 32'(dirty), 32'd1);
        autosave_en = 1'b0;
        m_dirty = 1'b1;
        repeat (3) tick();
        check("auto_off_idle", 32'(busy), 32'd0);

        // Media loss during sector 2 of a load.
        start(1);
        serve(1'b1, 2, 1'b0, 1'b0, wrote);
        check("abt_dirty", 32'(dirty), 32'(m_dirty));
        load_req = 1'b0;
        repeat (3) tick();
        check("abt_stays_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-save, then a clean restart.
        start(2);
        serve(1'b0, 2, 1'b1, 1'b0, wrote);
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);
        start(2);
        serve(1'b0, -1, 1'b0, 1'b0, wrote);
        check("post_rst_dirty", 32'(dirty), 32'(wrote));
        save_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
